dpsram_pipe: RTL

DPSRAM_PIPE -- requirements
Module: dpsram_pipe

---
 rtl/dpsram_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dpsram_pipe.sv
// Simple dual-port RAM with byte-enable writes, pipelined reads (latency 1 or 2),
// selectable collision behaviour and an optional zero-fill sweep after reset.
module dpsram_pipe #(
   parameter int BW_DATA     = 32,
   parameter int BW_ADDR     = 4,
   parameter int RD_LAT      = 1,
   parameter int RW_MODE     = 0,
   parameter int INIT_ON_RST = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wr_cen,
   input  logic [BW_ADDR-1:0]   i_wr_addr,
   input  logic [BW_DATA-1:0]   i_wr_data,
   input  logic [BW_DATA/8-1:0] i_wr_ben,
   input  logic                 i_rd_cen,
   input  logic [BW_ADDR-1:0]   i_rd_addr,
   input  logic                 i_rd_oen,
   output logic [BW_DATA-1:0]   o_rd_data,
   output logic                 o_rd_valid,
   output logic                 o_init_busy
);
   localparam int NB    = BW_DATA / 8;
   localparam int DEPTH = 2 ** BW_ADDR;
   localparam logic [BW_ADDR-1:0] LAST_ADDR = '1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t               state_reg;
   logic [BW_ADDR-1:0]   cnt_reg;
   logic [BW_DATA-1:0]   mem [DEPTH];

   logic                 init_we;
   logic                 wr_fire;
   logic                 rd_fire;
   logic [BW_ADDR-1:0]   wr_addr_mux;
   logic [BW_DATA-1:0]   wr_data_mux;
   logic [NB-1:0]        wr_mask;
   logic [NB-1:0]        byp_mask;

   logic                 s1_valid_reg;
   logic [BW_DATA-1:0]   s1_word_reg;
   logic [BW_DATA-1:0]   s1_byp_reg;
   logic [NB-1:0]        s1_mask_reg;
   logic [BW_DATA-1:0]   s1_data;

   logic [BW_DATA-1:0]   out_data;
   logic                 out_valid;

   // Busy is masked by reset so it reads low while reset is held.
   assign init_we     = (state_reg == S_INIT) && !i_rst;
   assign wr_fire     = (state_reg == S_RUN) && !i_rst && i_wr_cen;
   assign rd_fire     = (state_reg == S_RUN) && !i_rst && i_rd_cen;
   assign o_init_busy = init_we;
   assign wr_addr_mux = init_we ? cnt_reg : i_wr_addr;
   assign wr_data_mux = init_we ? '0 : i_wr_data;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_byte
         assign wr_mask[gi]  = init_we | (wr_fire & i_wr_ben[gi]);
         assign byp_mask[gi] = (RW_MODE != 0) && wr_fire && (i_wr_addr == i_rd_addr) && i_wr_ben[gi];
         assign s1_data[gi*8 +: 8] = s1_mask_reg[gi] ? s1_byp_reg[gi*8 +: 8] : s1_word_reg[gi*8 +: 8];
      end
   endgenerate

   // Sweep counter stops at the last address rather than wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= (INIT_ON_RST != 0) ? S_INIT : S_RUN;
         cnt_reg   <= '0;
      end else if (state_reg == S_INIT) begin
         if (cnt_reg == LAST_ADDR) begin
            state_reg <= S_RUN;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < NB; b++) begin
         if (wr_mask[b]) begin
            mem[wr_addr_mux][b*8 +: 8] <= wr_data_mux[b*8 +: 8];
         end
      end
   end

   // Stage 1 captures the pre-write word; write-first bytes are merged after the register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_reg <= 1'b0;
         s1_word_reg  <= '0;
         s1_byp_reg   <= '0;
         s1_mask_reg  <= '0;
      end else begin
         s1_valid_reg <= rd_fire;
         if (rd_fire) begin
            s1_word_reg <= mem[i_rd_addr];
            s1_byp_reg  <= i_wr_data;
            s1_mask_reg <= byp_mask;
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               out_valid <= 1'b0;
               out_data  <= '0;
            end else begin
               out_valid <= s1_valid_reg;
               if (s1_valid_reg) begin
                  out_data <= s1_data;
               end
            end
         end
      end else begin : g_lat1
         assign out_valid = s1_valid_reg;
         assign out_data  = s1_data;
      end
   endgenerate

   assign o_rd_data  = i_rd_oen ? out_data : '0;
   assign o_rd_valid = out_valid;

endmodule
